// File: rtl/judge_pkg.sv
// Shared definitions for the judgement scheduler: judge bit positions, per-judge
// gains and the game-state encoding.
package judge_pkg;

  localparam int JUDGE_PERFECT = 3;
  localparam int JUDGE_GREAT   = 2;
  localparam int JUDGE_GOOD    = 1;
  localparam int JUDGE_MISS    = 0;

  localparam int LIFE_GAIN_PERFECT = 4;
  localparam int LIFE_GAIN_GREAT   = 2;
  localparam int LIFE_GAIN_GOOD    = 0;
  localparam int LIFE_PENALTY_MISS = 20;

  localparam int SCORE_GAIN_PERFECT = 3;
  localparam int SCORE_GAIN_GREAT   = 2;
  localparam int SCORE_GAIN_GOOD    = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } game_state_e;

endpackage

// File: rtl/judge_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants one requester per cycle, searching from a rotating
// pointer that moves to the lane after the last grant.
module rr_arbiter
  import judge_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [LANES-1:0] req,
  input  logic             en,
  output logic [LANES-1:0] grant
);

  localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] cand;
  logic [PW-1:0] gnt_idx;
  logic          found;

  always_comb begin
    grant   = '0;
    gnt_idx = ptr_q;
    cand    = '0;
    found   = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      cand = PW'((int'(ptr_q) + i) % LANES);
      if (en && !found && req[cand]) begin
        grant[cand] = 1'b1;
        gnt_idx     = cand;
        found       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (found) begin
      ptr_q <= (gnt_idx == PW'(LANES - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/judge_scheduler.sv
// Buffers per-lane judgements, applies one per cycle to life/combo/score, runs the
// idle/play/over FSM and publishes results on the frame pulse.
// Optional: define JUDGE_COMBO_BONUS_EN to double score gains while combo >= 50.
module judge_scheduler
  import judge_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int LIFE_W    = 10,
  parameter int LIFE_MAX  = 330,
  parameter int LIFE_INIT = 165,
  parameter int COMBO_W   = 8,
  parameter int SCORE_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               frame_i,
  input  logic [3:0]         left_judge_i,
  input  logic [3:0]         up_judge_i,
  input  logic [3:0]         down_judge_i,
  input  logic [3:0]         right_judge_i,
  output logic [LIFE_W-1:0]  life_o,
  output logic [COMBO_W-1:0] combo_o,
  output logic [SCORE_W-1:0] score_o,
  output logic               playing_o,
  output logic               game_over_o,
  output logic               overflow_o
);

`ifdef JUDGE_COMBO_BONUS_EN
  localparam int COMBO_BONUS_THRESH = 50;
`endif

  function automatic logic [LIFE_W-1:0] sat_life(input logic signed [LIFE_W:0] v);
    if (v < 0)                          return '0;
    else if (v > (LIFE_W+1)'(LIFE_MAX)) return LIFE_W'(LIFE_MAX);
    else                                return v[LIFE_W-1:0];
  endfunction

  function automatic logic [COMBO_W-1:0] sat_combo_inc(input logic [COMBO_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  function automatic logic [SCORE_W-1:0] sat_score_add(input logic [SCORE_W-1:0] s,
                                                       input logic [SCORE_W-1:0] g);
    logic [SCORE_W:0] t;
    t = {1'b0, s} + {1'b0, g};
    return t[SCORE_W] ? '1 : t[SCORE_W-1:0];
  endfunction

  function automatic logic is_onehot(input logic [3:0] c);
    return (c != 4'd0) && ((c & (c - 4'd1)) == 4'd0);
  endfunction

  logic [3:0] judge_in [LANES];
  assign judge_in[0] = left_judge_i;
  assign judge_in[1] = up_judge_i;
  assign judge_in[2] = down_judge_i;
  assign judge_in[3] = right_judge_i;

  game_state_e               state_q;
  logic [LANES-1:0]          pend_vld_p0;
  logic [3:0]                pend_code_p0 [LANES];
  logic [LANES-1:0]          cap;
  logic [LANES-1:0]          grant;
  logic                      arb_en;
  logic [3:0]                gnt_code;
  logic [LIFE_W-1:0]         life_q, life_d;
  logic [COMBO_W-1:0]        combo_q, combo_d;
  logic [SCORE_W-1:0]        score_q, score_d;
  logic signed [LIFE_W:0]    life_delta;
  logic [SCORE_W-1:0]        score_gain;
  logic                      overflow_q;

  assign arb_en = (state_q == PLAY) && !start_i;

  rr_arbiter #(.LANES(LANES)) u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req    (pend_vld_p0),
    .en     (arb_en),
    .grant  (grant)
  );

  always_comb begin
    cap      = '0;
    gnt_code = '0;
    for (int l = 0; l < LANES; l++) begin
      cap[l] = (state_q == PLAY) && is_onehot(judge_in[l]);
      if (grant[l]) gnt_code = gnt_code | pend_code_p0[l];
    end
  end

  // Stage p0 -> working state: apply the granted judgement
  always_comb begin
    life_d     = life_q;
    combo_d    = combo_q;
    score_d    = score_q;
    life_delta = '0;
    score_gain = '0;
    if (|grant) begin
      if (gnt_code[JUDGE_PERFECT]) begin
        life_delta = (LIFE_W+1)'(LIFE_GAIN_PERFECT);
        score_gain = SCORE_W'(SCORE_GAIN_PERFECT);
      end else if (gnt_code[JUDGE_GREAT]) begin
        life_delta = (LIFE_W+1)'(LIFE_GAIN_GREAT);
        score_gain = SCORE_W'(SCORE_GAIN_GREAT);
      end else if (gnt_code[JUDGE_GOOD]) begin
        life_delta = (LIFE_W+1)'(LIFE_GAIN_GOOD);
        score_gain = SCORE_W'(SCORE_GAIN_GOOD);
      end else begin
        life_delta = -(LIFE_W+1)'(LIFE_PENALTY_MISS);
      end
`ifdef JUDGE_COMBO_BONUS_EN
      if (combo_q >= COMBO_W'(COMBO_BONUS_THRESH)) score_gain = score_gain << 1;
`endif
      life_d  = sat_life($signed({1'b0, life_q}) + life_delta);
      combo_d = gnt_code[JUDGE_MISS] ? '0 : sat_combo_inc(combo_q);
      score_d = sat_score_add(score_q, score_gain);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      life_q      <= LIFE_W'(LIFE_INIT);
      combo_q     <= '0;
      score_q     <= '0;
      overflow_q  <= 1'b0;
      pend_vld_p0 <= '0;
    end else if (start_i) begin
      state_q     <= PLAY;
      life_q      <= LIFE_W'(LIFE_INIT);
      combo_q     <= '0;
      score_q     <= '0;
      overflow_q  <= 1'b0;
      pend_vld_p0 <= '0;
    end else begin
      if (state_q == PLAY && life_q == '0) state_q <= OVER;
      life_q  <= life_d;
      combo_q <= combo_d;
      score_q <= score_d;
      // A granted slot frees up this edge, so a same-cycle capture refills it
      for (int l = 0; l < LANES; l++) begin
        if (cap[l] && (!pend_vld_p0[l] || grant[l])) pend_vld_p0[l] <= 1'b1;
        else if (grant[l])                            pend_vld_p0[l] <= 1'b0;
        if (cap[l] && pend_vld_p0[l] && !grant[l])    overflow_q     <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int l = 0; l < LANES; l++) begin
      if (cap[l] && (!pend_vld_p0[l] || grant[l])) pend_code_p0[l] <= judge_in[l];
    end
  end

  // Publish stage: frame-synchronous snapshot of the working values
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      life_o  <= LIFE_W'(LIFE_INIT);
      combo_o <= '0;
      score_o <= '0;
    end else if (frame_i) begin
      life_o  <= life_q;
      combo_o <= combo_q;
      score_o <= score_q;
    end
  end

  assign playing_o   = (state_q == PLAY);
  assign game_over_o = (state_q == OVER);
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_judge_scheduler.sv
// Directed bench for judge_scheduler: FSM, arbitration order, overflow, life clamp,
// saturation and the optional combo bonus.
module tb_judge_scheduler;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic        frame_i;
  logic [3:0]  left_judge_i, up_judge_i, down_judge_i, right_judge_i;
  logic [9:0]  life_o;
  logic [7:0]  combo_o;
  logic [15:0] score_o;
  logic        playing_o, game_over_o, overflow_o;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [3:0] PERFECT = 4'b1000;
  localparam logic [3:0] GOOD    = 4'b0010;
  localparam logic [3:0] MISS    = 4'b0001;

`ifdef JUDGE_COMBO_BONUS_EN
  localparam int SCORE_200 = 1050;
  localparam int SCORE_51  = 156;
`else
  localparam int SCORE_200 = 600;
  localparam int SCORE_51  = 153;
`endif

  judge_scheduler dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .frame_i       (frame_i),
    .left_judge_i  (left_judge_i),
    .up_judge_i    (up_judge_i),
    .down_judge_i  (down_judge_i),
    .right_judge_i (right_judge_i),
    .life_o        (life_o),
    .combo_o       (combo_o),
    .score_o       (score_o),
    .playing_o     (playing_o),
    .game_over_o   (game_over_o),
    .overflow_o    (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_i = 1'b1;
    tick();
    frame_i = 1'b0;
  endtask

  task automatic clear_judges();
    left_judge_i  = '0;
    up_judge_i    = '0;
    down_judge_i  = '0;
    right_judge_i = '0;
  endtask

  task automatic check_pub(input string tag, input int life, input int combo, input int score);
    check({tag, "_life"},  life_o,  life);
    check({tag, "_combo"}, combo_o, combo);
    check({tag, "_score"}, score_o, score);
  endtask

  initial begin
    rst_ni  = 1'b0;
    start_i = 1'b0;
    frame_i = 1'b0;
    clear_judges();
    #12;
    check_pub("reset", 165, 0, 0);
    check("reset_playing",  playing_o,   1'b0);
    check("reset_over",     game_over_o, 1'b0);
    check("reset_overflow", overflow_o,  1'b0);
    rst_ni = 1'b1;
    tick();

    // Start and first frame
    pulse_start();
    check("start_playing", playing_o, 1'b1);
    pulse_frame();
    check_pub("start_frame", 165, 0, 0);

    // Non-one-hot code is ignored
    up_judge_i = 4'b1100;
    tick();
    clear_judges();
    tick();
    pulse_frame();
    check_pub("nonhot", 165, 0, 0);
    check("nonhot_overflow", overflow_o, 1'b0);

    // Four simultaneous perfects: grant order left, up, down, right
    left_judge_i = PERFECT; up_judge_i = PERFECT; down_judge_i = PERFECT; right_judge_i = PERFECT;
    tick();
    clear_judges();
    check("grant1", dut.u_arb.grant, 4'b0001);
    tick();
    check("grant2", dut.u_arb.grant, 4'b0010);
    tick();
    check("grant3", dut.u_arb.grant, 4'b0100);
    tick();
    check("grant4", dut.u_arb.grant, 4'b1000);
    tick();
    check("prepublish_life", life_o, 165);
    pulse_frame();
    check_pub("four_perfect", 181, 4, 12);

    // Pointer moved to down by a single up event; a second left event is dropped
    pulse_start();
    up_judge_i = GOOD;
    tick();
    clear_judges();
    tick();
    left_judge_i = PERFECT; up_judge_i = PERFECT; down_judge_i = PERFECT; right_judge_i = PERFECT;
    tick();
    clear_judges();
    check("ovf_grant_down", dut.u_arb.grant, 4'b0100);
    check("ovf_before", overflow_o, 1'b0);
    left_judge_i = PERFECT;
    tick();
    clear_judges();
    check("ovf_after", overflow_o, 1'b1);
    repeat (4) tick();
    pulse_frame();
    check_pub("ovf", 181, 5, 13);
    pulse_start();
    check("ovf_cleared", overflow_o, 1'b0);

    // Nine misses drive life to zero and end the game
    for (int i = 0; i < 8; i++) begin
      left_judge_i = MISS;
      tick();
      clear_judges();
      tick();
    end
    pulse_frame();
    check_pub("eight_miss", 5, 0, 0);
    left_judge_i = MISS;
    tick();
    clear_judges();
    tick();
    check("zero_not_over_yet", game_over_o, 1'b0);
    tick();
    check("over", game_over_o, 1'b1);
    check("over_playing", playing_o, 1'b0);
    left_judge_i = PERFECT;
    repeat (3) tick();
    clear_judges();
    tick();
    pulse_frame();
    check_pub("over_ignored", 0, 0, 0);
    pulse_start();
    check("restart_playing", playing_o, 1'b1);
    pulse_frame();
    check_pub("restart", 165, 0, 0);

    // 200 perfects: life ceiling, then a miss
    pulse_start();
    left_judge_i = PERFECT;
    repeat (200) tick();
    clear_judges();
    tick();
    pulse_frame();
    check_pub("p200", 330, 200, SCORE_200);
    check("p200_overflow", overflow_o, 1'b0);
    left_judge_i = MISS;
    tick();
    clear_judges();
    tick();
    pulse_frame();
    check_pub("p200_miss", 310, 0, SCORE_200);

    // 51 perfects: combo bonus boundary
    pulse_start();
    left_judge_i = PERFECT;
    repeat (51) tick();
    clear_judges();
    tick();
    pulse_frame();
    check_pub("p51", 330, 51, SCORE_51);

    // Asynchronous reset mid-cycle
    #3;
    rst_ni = 1'b0;
    #1;
    check_pub("async_rst", 165, 0, 0);
    check("async_rst_playing", playing_o, 1'b0);
    check("async_rst_overflow", overflow_o, 1'b0);
    tick();
    rst_ni = 1'b1;
    tick();
    check("post_rst_idle", playing_o, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
